// File: rtl/target_reset_generator.sv
// I3C Target Reset Pattern generator: holds SCL low, makes 14 SDA transitions,
// then a Repeated START and a STOP, with every phase length programmable in cycles.
module target_reset_generator #(
  parameter int CntWidth = 20
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                start_i,
  input  logic [CntWidth-1:0] t_low_i,
  input  logic [CntWidth-1:0] t_su_sta_i,
  input  logic [CntWidth-1:0] t_hd_sta_i,
  input  logic [CntWidth-1:0] t_buf_i,
  output logic                scl_o,
  output logic                sda_o,
  output logic                busy_o,
  output logic                done_o
);

  typedef enum logic [2:0] {
    Idle,
    Prep,
    Toggle,
    SrSetup,
    SrHold,
    StopBuf
  } state_e;

  localparam logic [3:0] LastToggle = 4'd14;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [3:0]          tog_q, tog_d;
  logic [CntWidth-1:0] t_low_q, t_low_d;
  logic [CntWidth-1:0] t_su_sta_q, t_su_sta_d;
  logic [CntWidth-1:0] t_hd_sta_q, t_hd_sta_d;
  logic [CntWidth-1:0] t_buf_q, t_buf_d;
  logic                scl_d, sda_d, busy_d, done_d;

  // Counter preload for a phase of max(v,1) cycles; the phase ends when it reads zero.
  function automatic logic [CntWidth-1:0] phase_load(input logic [CntWidth-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  // Outputs are computed for the next state here and registered below, so the
  // pins change exactly on the cycle the FSM enters a phase.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    tog_d      = tog_q;
    t_low_d    = t_low_q;
    t_su_sta_d = t_su_sta_q;
    t_hd_sta_d = t_hd_sta_q;
    t_buf_d    = t_buf_q;
    scl_d      = scl_o;
    sda_d      = sda_o;
    busy_d     = busy_o;
    done_d     = 1'b0;

    if (state_q != Idle && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end

    case (state_q)
      Idle: begin
        if (enable_i && start_i) begin
          t_low_d    = t_low_i;
          t_su_sta_d = t_su_sta_i;
          t_hd_sta_d = t_hd_sta_i;
          t_buf_d    = t_buf_i;
          state_d    = Prep;
          cnt_d      = phase_load(t_low_i);
          tog_d      = '0;
          scl_d      = 1'b0;
          sda_d      = 1'b1;
          busy_d     = 1'b1;
        end
      end
      Prep: begin
        if (cnt_q == '0) begin
          state_d = Toggle;
          cnt_d   = phase_load(t_low_q);
          tog_d   = 4'd1;
          sda_d   = 1'b0;
        end
      end
      Toggle: begin
        if (cnt_q == '0) begin
          if (tog_q == LastToggle) begin
            // SDA is already high after an even number of transitions; only SCL moves.
            state_d = SrSetup;
            cnt_d   = phase_load(t_su_sta_q);
            scl_d   = 1'b1;
          end else begin
            cnt_d = phase_load(t_low_q);
            tog_d = tog_q + 4'd1;
            sda_d = ~sda_o;
          end
        end
      end
      SrSetup: begin
        if (cnt_q == '0) begin
          state_d = SrHold;
          cnt_d   = phase_load(t_hd_sta_q);
          sda_d   = 1'b0;
        end
      end
      SrHold: begin
        if (cnt_q == '0) begin
          state_d = StopBuf;
          cnt_d   = phase_load(t_buf_q);
          sda_d   = 1'b1;
        end
      end
      StopBuf: begin
        if (cnt_q == '0) begin
          state_d = Idle;
          tog_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = Idle;
        scl_d   = 1'b1;
        sda_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (rst_i) begin
      state_q    <= Idle;
      cnt_q      <= '0;
      tog_q      <= '0;
      t_low_q    <= '0;
      t_su_sta_q <= '0;
      t_hd_sta_q <= '0;
      t_buf_q    <= '0;
      scl_o      <= 1'b1;
      sda_o      <= 1'b1;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tog_q      <= tog_d;
      t_low_q    <= t_low_d;
      t_su_sta_q <= t_su_sta_d;
      t_hd_sta_q <= t_hd_sta_d;
      t_buf_q    <= t_buf_d;
      scl_o      <= scl_d;
      sda_o      <= sda_d;
      busy_o     <= busy_d;
      done_o     <= done_d;
    end
  end

endmodule
